// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET_ASSERT = 2'd0,
    ST_WAIT_LOCK    = 2'd1,
    ST_STABLE       = 2'd2,
    ST_RUN          = 2'd3
  } pll_state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  // Largest of three values; sizes the shared phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the async input through STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout and retry,
// qualifies lock as stable, then releases core_reset until lock is lost or relock is requested.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  core_reset,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [1:0]            state_o
);

  localparam int unsigned TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};

  pll_state_e           state, state_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic [RETRY_W-1:0]   retry, retry_nx, retry_inc;
  logic                 fail_nx;
  logic [LOSS_CNT_W-1:0] loss_nx;
  logic                 locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // State, timer, counters and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= ST_RESET_ASSERT;
      timer      <= '0;
      retry      <= '0;
      fail       <= 1'b0;
      loss_cnt   <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      retry      <= retry_nx;
      fail       <= fail_nx;
      loss_cnt   <= loss_nx;
      pll_rst    <= (state_nx == ST_RESET_ASSERT);
      core_reset <= (state_nx != ST_RUN);
    end
  end

  // Next-state, timer and counter update.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer + TIMER_W'(1);
    retry_nx  = retry;
    fail_nx   = fail;
    loss_nx   = loss_cnt;
    retry_inc = (retry == RETRY_W'(MAX_RETRIES)) ? retry : retry + RETRY_W'(1);

    unique case (state)
      ST_RESET_ASSERT: begin
        if (timer == TIMER_W'(RST_CYCLES - 1)) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_nx = ST_RESET_ASSERT;
        end else if (locked_s) begin
          state_nx = ST_STABLE;
        end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
          state_nx = ST_RESET_ASSERT;
          retry_nx = retry_inc;
          if (retry_inc == RETRY_W'(MAX_RETRIES)) fail_nx = 1'b1;
        end
      end
      ST_STABLE: begin
        if (relock_req)                              state_nx = ST_RESET_ASSERT;
        else if (!locked_s)                          state_nx = ST_WAIT_LOCK;
        else if (timer == TIMER_W'(STABLE_CYCLES - 1)) state_nx = ST_RUN;
      end
      ST_RUN: begin
        retry_nx = '0;
        if (relock_req) begin
          state_nx = ST_RESET_ASSERT;
        end else if (!locked_s) begin
          state_nx = ST_RESET_ASSERT;
          if (loss_cnt != LOSS_MAX) loss_nx = loss_cnt + LOSS_CNT_W'(1);
        end
      end
      default: state_nx = ST_RESET_ASSERT;
    endcase

    // Every phase starts its count from zero.
    if (state_nx != state) timer_nx = '0;
  end

  assign state_o = state;

endmodule
